membus_arbiter: RTL
===================

Name: membus_arbiter

Overview:
- Shares the single 32-bit memory bus (main RAM + character ROM) between three requesters: CPU register-bus master, layer 1 renderer, layer 2 renderer.
- Fixed priority to the CPU, round-robin between the two layer renderers, and a starvation guard so sustained CPU traffic cannot stall line rendering.
- Drives the memory-bus address/write/byte-select lines combinationally. Returns a registered per-requester ack aligned with the memory's one-cycle read latency.

Parameters:
- MAX_WAIT, 8: consecutive cycles a pending layer request may lose to the CPU before it is force-granted (1..15).
- WAIT_W, 4: width of the starvation counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock (25 MHz pixel clock domain)
- rst  in  1  asynchronous, active-high reset
- cpu_strobe  in  1  CPU request; held until cpu_ack
- cpu_write  in  1  1 = write, 0 = read
- cpu_addr  in  18  CPU byte address
- cpu_wrdata  in  8  CPU write byte
- cpu_ack  out  1  CPU access completed; read data valid on memory read bus this cycle
- l1_strobe  in  1  layer 1 read request; held until l1_ack
- l1_addr  in  18  layer 1 byte address
- l1_ack  out  1  layer 1 access completed; read data valid this cycle
- l2_strobe  in  1  layer 2 read request; held until l2_ack
- l2_addr  in  18  layer 2 byte address
- l2_ack  out  1  layer 2 access completed; read data valid this cycle
- mem_strobe  out  1  memory access this cycle
- mem_write  out  1  memory write enable
- mem_addr  out  18  memory byte address
- mem_wrdata  out  32  cpu_wrdata replicated 4x
- mem_bytesel  out  4  one-hot lane select from mem_addr[1:0] (00->0001, 01->0010, 10->0100, 11->1000)
- grant_id  out  2  registered owner of the access being acked: 0 none, 1 cpu, 2 l1, 3 l2

Behaviour:
- Reset: all acks 0, grant_id 0, starvation counter 0, round-robin pointer selects l1 as next layer.
- Grant decision is combinational in cycle N, with at most one grant per cycle:
  - If force is asserted (starve_cnt == MAX_WAIT and a layer strobe is pending), grant the RR-selected pending layer.
  - Else if cpu_strobe, grant cpu.
  - Else grant the RR-selected pending layer.
  - Else grant none.
- Round-robin selection:
  - Only one layer pending: that layer.
  - Both pending: the layer not granted most recently.
  - The pointer updates only when a layer is actually granted.
- Memory-side outputs in cycle N:
  - mem_strobe = any grant.
  - mem_addr = granted requester's address; 0 when idle.
  - mem_write = cpu_write only when cpu is granted, else 0. A layer grant never writes.
- Ack is registered: x_ack in cycle N+1 = granted-x in cycle N. grant_id is registered identically.
  - Every ack is a single-cycle pulse.
  - A requester whose strobe remains high after its ack is treated as a new request in that cycle and may be granted back-to-back.
- Starvation counter (WAIT_W bits, saturates at MAX_WAIT):
  - Increments when any layer strobe is pending and cpu is granted.
  - Clears when a layer is granted, or when no layer strobe is pending.
  - Holds otherwise.
- Forced layer grant: cpu receives no grant that cycle; its strobe stays pending and it wins the next cycle (counter now 0).
- A strobe deasserted before its ack is a requester protocol violation. The arbiter simply stops considering that requester; no ack is generated for it.
- Reset mid-access: outputs clear immediately (async). An ack pending for the next cycle is dropped, and requesters must reissue after reset release.
- Worst-case layer latency under saturated CPU traffic: MAX_WAIT+1 cycles to grant, +1 to ack.
- Worst-case for one layer with the other layer also saturating: one extra round-robin slot.

Test Plan:
- Reset, all strobes low -> mem_strobe=0, mem_addr=0, all acks 0, grant_id=0 indefinitely.
- CPU write addr 0x00006, data 0xA5, single strobe -> cycle N: mem_write=1, mem_addr=0x00006, mem_bytesel=0100, mem_wrdata=0xA5A5A5A5; cycle N+1: cpu_ack=1, grant_id=1; cycle N+2: cpu_ack=0.
- l1_strobe and l2_strobe held continuously, CPU idle -> acks alternate l1,l2,l1,l2 one per cycle, with l1 first after reset; mem_write stays 0.
- CPU strobe held continuously plus l1_strobe from cycle 0, MAX_WAIT=8 -> cpu_ack in cycles 1..8; cycle 8 grants l1 (l1_ack in cycle 9, cpu_ack=0 in cycle 9); CPU resumes acks from cycle 10; counter is back at 0.
- CPU read and l2 read asserted in the same cycle, counter 0 -> CPU granted first, l2 granted in the next cycle, acks on consecutive cycles with grant_id 1 then 3.
- Assert rst while a grant is outstanding (between grant and ack) -> no ack in the following cycle, counter/pointer at reset values; after release, a repeated request is acked normally with 1-cycle latency.

Source files
------------

// File: rtl/membus_arbiter_if.sv
// Request/ack and memory-bus signal bundle for membus_arbiter.
// slave = arbiter side, master = requesters and memory observers.
interface membus_arbiter_if;
    logic        cpu_strobe;
    logic        cpu_write;
    logic [17:0] cpu_addr;
    logic [7:0]  cpu_wrdata;
    logic        cpu_ack;
    logic        l1_strobe;
    logic [17:0] l1_addr;
    logic        l1_ack;
    logic        l2_strobe;
    logic [17:0] l2_addr;
    logic        l2_ack;
    logic        mem_strobe;
    logic        mem_write;
    logic [17:0] mem_addr;
    logic [31:0] mem_wrdata;
    logic [3:0]  mem_bytesel;
    logic [1:0]  grant_id;

    modport slave (
        input  cpu_strobe, cpu_write, cpu_addr, cpu_wrdata,
        input  l1_strobe, l1_addr, l2_strobe, l2_addr,
        output cpu_ack, l1_ack, l2_ack,
        output mem_strobe, mem_write, mem_addr, mem_wrdata, mem_bytesel, grant_id
    );

    modport master (
        output cpu_strobe, cpu_write, cpu_addr, cpu_wrdata,
        output l1_strobe, l1_addr, l2_strobe, l2_addr,
        input  cpu_ack, l1_ack, l2_ack,
        input  mem_strobe, mem_write, mem_addr, mem_wrdata, mem_bytesel, grant_id
    );
endinterface

// File: rtl/membus_arbiter.sv
// Memory-bus arbiter: CPU priority, l1/l2 round-robin, starvation force-grant.
// Grant is combinational; ack/grant_id are registered one cycle later; losers just wait.
module membus_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4
) (
    input logic             clk,
    input logic             rst,
    membus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_L1   = 2'd2,
        GNT_L2   = 2'd3
    } grant_t;

    logic [WAIT_W-1:0] starve_cnt;
    logic              rr_next_l2;
    logic              layer_pend;
    logic              force_layer;
    grant_t            layer_sel;
    grant_t            grant;
    logic [17:0]       sel_addr;

    always_comb begin
        layer_pend = bus.l1_strobe | bus.l2_strobe;
        layer_sel  = GNT_NONE;
        if (bus.l1_strobe && bus.l2_strobe) begin
            layer_sel = rr_next_l2 ? GNT_L2 : GNT_L1;
        end else if (bus.l1_strobe) begin
            layer_sel = GNT_L1;
        end else if (bus.l2_strobe) begin
            layer_sel = GNT_L2;
        end

        force_layer = layer_pend && (starve_cnt == WAIT_W'(MAX_WAIT));

        // Reset also blanks the combinational bus so nothing is issued during reset.
        grant = GNT_NONE;
        if (rst) begin
            grant = GNT_NONE;
        end else if (force_layer) begin
            grant = layer_sel;
        end else if (bus.cpu_strobe) begin
            grant = GNT_CPU;
        end else begin
            grant = layer_sel;
        end
    end

    always_comb begin
        sel_addr = 18'd0;
        unique case (grant)
            GNT_CPU:  sel_addr = bus.cpu_addr;
            GNT_L1:   sel_addr = bus.l1_addr;
            GNT_L2:   sel_addr = bus.l2_addr;
            default:  sel_addr = 18'd0;
        endcase
    end

    assign bus.mem_strobe  = (grant != GNT_NONE);
    assign bus.mem_write   = (grant == GNT_CPU) && bus.cpu_write;
    assign bus.mem_addr    = sel_addr;
    assign bus.mem_wrdata  = {4{bus.cpu_wrdata}};
    assign bus.mem_bytesel = 4'b0001 << sel_addr[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cpu_ack  <= 1'b0;
            bus.l1_ack   <= 1'b0;
            bus.l2_ack   <= 1'b0;
            bus.grant_id <= 2'd0;
            starve_cnt   <= '0;
            rr_next_l2   <= 1'b0;
        end else begin
            bus.cpu_ack  <= (grant == GNT_CPU);
            bus.l1_ack   <= (grant == GNT_L1);
            bus.l2_ack   <= (grant == GNT_L2);
            bus.grant_id <= grant;
            if (grant == GNT_L1 || grant == GNT_L2) begin
                rr_next_l2 <= (grant == GNT_L1);
                starve_cnt <= '0;
            end else if (!layer_pend) begin
                starve_cnt <= '0;
            end else if (grant == GNT_CPU && starve_cnt != WAIT_W'(MAX_WAIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule
